// File: rtl/bg_pkg.sv
// Shared encodings for the bandgap SAR trim controller: FSM states, search phases,
// sample-capacitor phase codes and the chopped-comparator hit count.
package bg_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_DIODE    = 4'd1,
    ST_BLANK1   = 4'd2,
    ST_BIGDIODE = 4'd3,
    ST_BLANK2   = 4'd4,
    ST_COMPARE  = 4'd5,
    ST_SETTLE   = 4'd6,
    ST_DECIDE   = 4'd7,
    ST_OUTPUT   = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    PH_COARSE = 2'd0,
    PH_FINE   = 2'd1,
    PH_TRACK  = 2'd2
  } phase_e;

  localparam logic [1:0] CAP_OFF = 2'd0;
  localparam logic [1:0] CAP_CMP = 2'd1;
  localparam logic [1:0] CAP_CHG = 2'd2;

  localparam logic [3:0] OSEL_TRIM = 4'b1110;
  localparam logic [3:0] OSEL_REF  = 4'b1101;

  // Second pass runs with the comparator inverted, so a "hit" there is cmpo low.
  function automatic logic [1:0] hit_count(input logic cmp_pass0, input logic cmp_pass1);
    return {1'b0, cmp_pass0} + {1'b0, ~cmp_pass1};
  endfunction

endpackage

// File: rtl/bg_sar_reg.sv
// Successive-approximation register: start loads MSB-only, each decide resolves the
// current bit and trial-sets the next lower one; load overwrites the code directly.
module bg_sar_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         decide,
  input  logic         bit_val,
  output logic [W-1:0] code,
  output logic         last
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(W - 1);

  logic [W-1:0]  code_reg, code_next;
  logic [IW-1:0] idx_reg, idx_next;

  always_comb begin
    code_next = code_reg;
    idx_next  = idx_reg;
    if (load) begin
      code_next = load_val;
      idx_next  = '0;
    end else if (start) begin
      code_next        = '0;
      code_next[W-1]   = 1'b1;
      idx_next         = IDX_MSB;
    end else if (decide) begin
      code_next[idx_reg] = bit_val;
      if (idx_reg != '0) begin
        code_next[idx_reg - 1'b1] = 1'b1;
        idx_next                  = idx_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg <= RST_VAL;
      idx_reg  <= '0;
    end else begin
      code_reg <= code_next;
      idx_reg  <= idx_next;
    end
  end

  assign code = code_reg;
  assign last = (idx_reg == '0);

endmodule

// File: rtl/bg_sar_ctrl.sv
// Bandgap trim controller: coarse SAR, chopped fine SAR, then chopped tracking of the
// fine code with a periodic OUTPUT window in which the reference is flagged valid.
module bg_sar_ctrl
  import bg_pkg::*;
#(
  parameter int COARSE_W   = 8,
  parameter int FINE_W     = 8,
  parameter int NDIODE     = 8,
  parameter int SETTLE_CYC = 1,
  parameter int OUT_CYC    = 5,
  parameter int RESET_CYC  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pwrup,
  input  logic                cmpo,
  output logic [COARSE_W-1:0] idac_coarse,
  output logic [FINE_W-1:0]   idac_fine,
  output logic [3:0]          idac_out_select_n,
  output logic [NDIODE-1:0]   diode_select,
  output logic                res_ptat_enable_n,
  output logic [1:0]          c1,
  output logic [1:0]          c2,
  output logic                cmp_swap_input,
  output logic [3:0]          state,
  output logic [1:0]          phase,
  output logic                valid,
  output logic                locked
);

  // Asynchronous assert, release aligned to clk after two flops.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [3:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [1:0] phase_reg, phase_next;
  logic       valid_reg, valid_next;
  logic       locked_reg, locked_next;
  logic       swap_reg, swap_next;
  logic       pass_reg, pass_next;
  logic       hit0_reg, hit0_next;

  logic              coarse_load, coarse_start, coarse_decide, coarse_bit, coarse_last;
  logic              fine_load, fine_start, fine_decide, fine_bit, fine_last;
  logic [FINE_W-1:0] fine_load_val;
  logic [1:0]        hits;

  assign hits = hit_count(hit0_reg, cmpo);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    phase_next    = phase_reg;
    valid_next    = 1'b0;
    locked_next   = locked_reg;
    swap_next     = swap_reg;
    pass_next     = pass_reg;
    hit0_next     = hit0_reg;
    coarse_load   = 1'b0;
    coarse_start  = 1'b0;
    coarse_decide = 1'b0;
    coarse_bit    = 1'b0;
    fine_load     = 1'b0;
    fine_load_val = idac_fine;
    fine_start    = 1'b0;
    fine_decide   = 1'b0;
    fine_bit      = 1'b0;

    case (state_reg)
      ST_RESET: begin
        coarse_start = 1'b1;
        fine_start   = 1'b1;
        phase_next   = PH_COARSE;
        locked_next  = 1'b0;
        swap_next    = 1'b0;
        pass_next    = 1'b0;
        if (cnt_reg == 4'(RESET_CYC - 1)) begin
          state_next = ST_DIODE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_DIODE:    state_next = ST_BLANK1;
      ST_BLANK1:   state_next = ST_BIGDIODE;
      ST_BIGDIODE: state_next = ST_BLANK2;
      ST_BLANK2:   state_next = ST_COMPARE;
      ST_COMPARE: begin
        state_next = ST_SETTLE;
        cnt_next   = '0;
      end
      ST_SETTLE: begin
        if (cnt_reg == 4'(SETTLE_CYC - 1)) begin
          state_next = ST_DECIDE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_DECIDE: begin
        if (phase_reg == PH_COARSE) begin
          coarse_decide = 1'b1;
          coarse_bit    = ~cmpo;
          state_next    = ST_DIODE;
          if (coarse_last) begin
            phase_next = PH_FINE;
            fine_start = 1'b1;
          end
        end else if (!pass_reg) begin
          hit0_next  = cmpo;
          pass_next  = 1'b1;
          swap_next  = 1'b1;
          state_next = ST_DIODE;
        end else begin
          pass_next = 1'b0;
          swap_next = 1'b0;
          if (phase_reg == PH_FINE) begin
            fine_decide = 1'b1;
            fine_bit    = (hits == 2'd2);
            if (fine_last) begin
              locked_next = 1'b1;
              phase_next  = PH_TRACK;
              state_next  = ST_OUTPUT;
              cnt_next    = '0;
            end else begin
              state_next = ST_DIODE;
            end
          end else begin
            fine_load = 1'b1;
            if (hits == 2'd2 && idac_fine != '1)      fine_load_val = idac_fine + 1'b1;
            else if (hits == 2'd0 && idac_fine != '0) fine_load_val = idac_fine - 1'b1;
            state_next = ST_OUTPUT;
            cnt_next   = '0;
          end
        end
      end
      ST_OUTPUT: begin
        if (cnt_reg == 4'(OUT_CYC - 1)) begin
          state_next = ST_DIODE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + 4'd1;
          // valid covers the 3rd cycle of the window through the last
          valid_next = (cnt_reg >= 4'd1);
        end
      end
      default: begin
        state_next = ST_RESET;
        cnt_next   = '0;
      end
    endcase

    if (!pwrup) begin
      state_next    = ST_RESET;
      cnt_next      = '0;
      phase_next    = PH_COARSE;
      valid_next    = 1'b0;
      locked_next   = 1'b0;
      swap_next     = 1'b0;
      pass_next     = 1'b0;
      hit0_next     = 1'b0;
      coarse_start  = 1'b0;
      coarse_decide = 1'b0;
      fine_start    = 1'b0;
      fine_decide   = 1'b0;
      coarse_load   = 1'b1;
      fine_load     = 1'b1;
      fine_load_val = '1;
    end
  end

  // Analog controls are registered from the next state so they never glitch.
  logic [1:0]        c1_reg, c1_next, c2_reg, c2_next;
  logic [NDIODE-1:0] diode_reg, diode_next;
  logic              ptat_n_reg, ptat_n_next;
  logic [3:0]        osel_reg, osel_next;

  always_comb begin
    c1_next     = CAP_CHG;
    c2_next     = CAP_CHG;
    diode_next  = '1;
    ptat_n_next = 1'b1;
    osel_next   = OSEL_TRIM;
    case (state_next)
      ST_DIODE: begin
        diode_next = NDIODE'(1);
        c2_next    = CAP_OFF;
      end
      ST_BLANK1: begin
        diode_next = NDIODE'(1);
        c1_next    = CAP_OFF;
        c2_next    = CAP_OFF;
      end
      ST_BIGDIODE: begin
        c1_next     = CAP_OFF;
        ptat_n_next = 1'b0;
      end
      ST_BLANK2: begin
        c1_next     = CAP_OFF;
        c2_next     = CAP_OFF;
        ptat_n_next = 1'b0;
      end
      ST_COMPARE, ST_SETTLE, ST_DECIDE: begin
        c1_next     = CAP_CMP;
        c2_next     = CAP_CMP;
        ptat_n_next = 1'b0;
      end
      ST_OUTPUT: begin
        c1_next     = CAP_OFF;
        c2_next     = CAP_OFF;
        ptat_n_next = 1'b0;
        osel_next   = OSEL_REF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RESET;
      cnt_reg    <= '0;
      phase_reg  <= PH_COARSE;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
      swap_reg   <= 1'b0;
      pass_reg   <= 1'b0;
      hit0_reg   <= 1'b0;
      c1_reg     <= CAP_CHG;
      c2_reg     <= CAP_CHG;
      diode_reg  <= '1;
      ptat_n_reg <= 1'b1;
      osel_reg   <= OSEL_TRIM;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
      swap_reg   <= swap_next;
      pass_reg   <= pass_next;
      hit0_reg   <= hit0_next;
      c1_reg     <= c1_next;
      c2_reg     <= c2_next;
      diode_reg  <= diode_next;
      ptat_n_reg <= ptat_n_next;
      osel_reg   <= osel_next;
    end
  end

  bg_sar_reg #(.W(COARSE_W), .RST_VAL('0)) u_coarse (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (coarse_load),
    .load_val ('0),
    .start    (coarse_start),
    .decide   (coarse_decide),
    .bit_val  (coarse_bit),
    .code     (idac_coarse),
    .last     (coarse_last)
  );

  bg_sar_reg #(.W(FINE_W), .RST_VAL('1)) u_fine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (fine_load),
    .load_val (fine_load_val),
    .start    (fine_start),
    .decide   (fine_decide),
    .bit_val  (fine_bit),
    .code     (idac_fine),
    .last     (fine_last)
  );

  assign state             = state_reg;
  assign phase             = phase_reg;
  assign valid             = valid_reg;
  assign locked            = locked_reg;
  assign cmp_swap_input    = swap_reg;
  assign c1                = c1_reg;
  assign c2                = c2_reg;
  assign diode_select      = diode_reg;
  assign res_ptat_enable_n = ptat_n_reg;
  assign idac_out_select_n = osel_reg;

endmodule

// File: tb/tb_bg_sar_ctrl.sv
// Directed bench for bg_sar_ctrl: expected values are queued when stimulus is set up
// and popped when the DUT reaches the matching point.
module tb_bg_sar_ctrl;

  logic       clk;
  logic       reset_n;
  logic       pwrup;
  logic       cmpo;
  logic [7:0] idac_coarse;
  logic [7:0] idac_fine;
  logic [3:0] idac_out_select_n;
  logic [7:0] diode_select;
  logic       res_ptat_enable_n;
  logic [1:0] c1;
  logic [1:0] c2;
  logic       cmp_swap_input;
  logic [3:0] state;
  logic [1:0] phase;
  logic       valid;
  logic       locked;

  bg_sar_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pwrup             (pwrup),
    .cmpo              (cmpo),
    .idac_coarse       (idac_coarse),
    .idac_fine         (idac_fine),
    .idac_out_select_n (idac_out_select_n),
    .diode_select      (diode_select),
    .res_ptat_enable_n (res_ptat_enable_n),
    .c1                (c1),
    .c2                (c2),
    .cmp_swap_input    (cmp_swap_input),
    .state             (state),
    .phase             (phase),
    .valid             (valid),
    .locked            (locked)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  int          total_cnt = 0;

  // Comparator stimulus: a threshold model, or fixed levels per chop pass.
  logic       use_model;
  logic [7:0] thr_c, thr_f;
  logic       f0, f1;

  task automatic update_cmpo();
    if (use_model) begin
      if (phase == 2'd0) cmpo = (idac_coarse > thr_c);
      else               cmpo = (idac_fine <= thr_f) ^ cmp_swap_input;
    end else begin
      cmpo = cmp_swap_input ? f1 : f0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update_cmpo();
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s observed=%0h required=%0h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check(obs);
  endtask

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      0:       return 32'(state);
      1:       return 32'(phase);
      default: return 32'(locked);
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic [31:0] target, input int budget,
                          output int waited);
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (get_sig(sel) == target) break;
      tick();
      waited++;
    end
  endtask

  initial begin
    int         n;
    logic [7:0] exp_code;

    reset_n = 1'b0; pwrup = 1'b1; cmpo = 1'b0;
    use_model = 1'b0; f0 = 1'b0; f1 = 1'b0; thr_c = 8'h5A; thr_f = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_coarse", idac_coarse, 8'h00);
    chk("rst_fine", idac_fine, 8'hFF);
    chk("rst_osel", idac_out_select_n, 4'b1110);
    chk("rst_diode", diode_select, 8'hFF);
    chk("rst_ptat_n", res_ptat_enable_n, 1);
    chk("rst_c1c2", {c1, c2}, 4'b1010);
    chk("rst_swap", cmp_swap_input, 0);
    chk("rst_valid_locked", {valid, locked}, 0);
    chk("rst_phase", phase, 0);

    // Comparator stuck low: every coarse bit is kept.
    reset_n = 1'b1;
    update_cmpo();
    wait_for(0, 1, 50, n);
    chk("first_diode", state, 1);
    chk("start_codes", {idac_coarse, idac_fine}, 16'h8080);
    wait_for(1, 1, 200, n);
    chk("cmp0_phase_fine", phase, 1);
    chk("cmp0_coarse", idac_coarse, 8'hFF);
    chk("coarse_cycles", n, 56);

    // Power loss in the middle of the fine search.
    repeat (20) tick();
    chk("fine_mid_phase", phase, 1);
    pwrup = 1'b0;
    tick();
    chk("drop_state", state, 0);
    chk("drop_codes", {idac_coarse, idac_fine}, 16'h00FF);
    chk("drop_locked", locked, 0);
    repeat (2) tick();
    chk("drop_hold", state, 0);
    pwrup = 1'b1;
    use_model = 1'b1;
    update_cmpo();
    repeat (4) tick();
    chk("dwell_4", state, 0);
    tick();
    chk("dwell_5_diode", state, 1);
    chk("diode_sel", diode_select, 8'h01);
    chk("diode_c1c2", {c1, c2}, 4'b1000);
    chk("diode_ptat_n", res_ptat_enable_n, 1);
    tick();
    chk("blank1_c1c2", {c1, c2}, 4'b0000);
    tick();
    chk("bigdiode_sel", diode_select, 8'hFF);
    chk("bigdiode_ptat_n", res_ptat_enable_n, 0);
    chk("bigdiode_c1c2", {c1, c2}, 4'b0010);
    repeat (2) tick();
    chk("compare_state", state, 5);
    chk("compare_c1c2", {c1, c2}, 4'b0101);

    // Threshold model: coarse converges to 5A, fine to 80.
    wait_for(1, 1, 200, n);
    chk("model_coarse", idac_coarse, 8'h5A);
    chk("pass0_swap", cmp_swap_input, 0);
    wait_for(0, 7, 20, n);
    tick();
    chk("pass1_state", state, 1);
    chk("pass1_swap", cmp_swap_input, 1);
    wait_for(2, 1, 400, n);
    chk("lock_flag", locked, 1);
    chk("lock_fine", idac_fine, 8'h80);
    chk("lock_phase", phase, 2);
    chk("lock_state", state, 8);
    chk("out_swap", cmp_swap_input, 0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("valid_cyc%0d", k), valid, (k >= 3));
      chk($sformatf("osel_cyc%0d", k), idac_out_select_n, 4'b1101);
      tick();
    end
    chk("post_out_state", state, 1);
    chk("post_out_valid", valid, 0);

    // TRACK with h=1 (both passes high): code holds.
    use_model = 1'b0; f0 = 1'b1; f1 = 1'b1;
    update_cmpo();
    for (int k = 0; k < 2; k++) begin
      expect_val("track_hold", 8'h80);
      wait_for(0, 8, 100, n);
      check(idac_fine);
      wait_for(0, 1, 100, n);
    end

    // TRACK with h=2: increment, saturating at FF.
    f0 = 1'b1; f1 = 1'b0;
    update_cmpo();
    exp_code = 8'h80;
    for (int k = 0; k < 130; k++) begin
      exp_code = (exp_code == 8'hFF) ? 8'hFF : exp_code + 8'h01;
      expect_val($sformatf("track_inc%0d", k), exp_code);
      wait_for(0, 8, 100, n);
      check(idac_fine);
      wait_for(0, 1, 100, n);
    end

    // TRACK with h=0: decrement, saturating at 00.
    f0 = 1'b0; f1 = 1'b1;
    update_cmpo();
    for (int k = 0; k < 258; k++) begin
      exp_code = (exp_code == 8'h00) ? 8'h00 : exp_code - 8'h01;
      expect_val($sformatf("track_dec%0d", k), exp_code);
      wait_for(0, 8, 100, n);
      check(idac_fine);
      wait_for(0, 1, 100, n);
    end

    // Fresh search with h=1 on every fine bit: all fine bits clear.
    pwrup = 1'b0;
    tick();
    pwrup = 1'b1; f0 = 1'b1; f1 = 1'b1;
    update_cmpo();
    wait_for(2, 1, 800, n);
    chk("h1_lock", locked, 1);
    chk("h1_fine", idac_fine, 8'h00);
    chk("h1_coarse", idac_coarse, 8'h00);

    // Power loss inside the OUTPUT window wins over it.
    repeat (2) tick();
    chk("win_valid", valid, 1);
    pwrup = 1'b0;
    tick();
    chk("win_drop_state", state, 0);
    chk("win_drop_flags", {valid, locked}, 0);
    chk("win_drop_fine", idac_fine, 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
